// File: rtl/trap_controller_pkg.sv
// Shared types and constants for the trap controller.
// States, cause codes, the interrupt flag bit and the trap-value source selector.
// No logic; imported by trap_controller and trap_prio_encoder.
package trap_controller_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        TRAP_ENTER = 2'd1,
        MRET_EXIT  = 2'd2
    } state_e;

    // Which value is written to the trap-value capture register
    typedef enum logic [1:0] {
        TVAL_ZERO    = 2'd0,
        TVAL_BADADDR = 2'd1,
        TVAL_INSTR   = 2'd2,
        TVAL_PC      = 2'd3
    } tval_sel_e;

    localparam logic [31:0] INT_BIT = 32'h8000_0000;

    localparam logic [31:0] CAUSE_FETCH_MIS = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL   = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
    localparam logic [31:0] CAUSE_LOAD_MIS  = 32'd4;
    localparam logic [31:0] CAUSE_STORE_MIS = 32'd6;
    localparam logic [31:0] CAUSE_ECALL_M   = 32'd11;
    localparam logic [31:0] CAUSE_IRQ_TIMER = INT_BIT | 32'd7;

endpackage

// File: rtl/trap_controller_prio.sv
// trap_prio_encoder: picks the highest-priority pending trap and its cause/tval source.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is acted upon.
module trap_prio_encoder
    import trap_controller_pkg::*;
(
    input  logic        mtime_exc,
    input  logic        exc_fetch_mis,
    input  logic        exc_illegal,
    input  logic        exc_ecall,
    input  logic        exc_ebreak,
    input  logic        exc_load_mis,
    input  logic        exc_store_mis,
    output logic        trap_vld,
    output logic [31:0] trap_cause,
    output tval_sel_e   tval_sel
);

    // Fixed priority: timer interrupt first, then synchronous exceptions
    always_comb begin
        trap_vld   = 1'b1;
        trap_cause = 32'd0;
        tval_sel   = TVAL_ZERO;
        if (mtime_exc) begin
            trap_cause = CAUSE_IRQ_TIMER;
        end else if (exc_fetch_mis) begin
            trap_cause = CAUSE_FETCH_MIS;
            tval_sel   = TVAL_BADADDR;
        end else if (exc_illegal) begin
            trap_cause = CAUSE_ILLEGAL;
            tval_sel   = TVAL_INSTR;
        end else if (exc_ecall) begin
            trap_cause = CAUSE_ECALL_M;
        end else if (exc_ebreak) begin
            trap_cause = CAUSE_EBREAK;
            tval_sel   = TVAL_PC;
        end else if (exc_load_mis) begin
            trap_cause = CAUSE_LOAD_MIS;
            tval_sel   = TVAL_BADADDR;
        end else if (exc_store_mis) begin
            trap_cause = CAUSE_STORE_MIS;
            tval_sel   = TVAL_BADADDR;
        end else begin
            trap_vld   = 1'b0;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// trap_controller: stalls commit on a trap/MRET, then redirects fetch for one cycle.
// Latency: stall same cycle as detection, redirect/flush exactly one cycle later.
// Backpressure: stall_o blocks commit; inputs ignored while redirecting. Option: TRAP_VECTORED_EN.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int VECTOR_STRIDE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] badaddr_i,
    input  logic        exc_fetch_mis_i,
    input  logic        exc_illegal_i,
    input  logic        exc_ecall_i,
    input  logic        exc_ebreak_i,
    input  logic        exc_load_mis_i,
    input  logic        exc_store_mis_i,
    input  logic        mret_i,
    input  logic        mtime_exc_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        jumpingToMtvec_o,
    output logic [31:0] excCause_o,
    output logic [31:0] trapInfo_o,
    output logic [31:0] trap_pc_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        mret_o
);

    state_e      state_q, state_d;
    logic [31:0] cause_q, tval_q, pc_q;
    logic        capture;

    logic        trap_vld;
    logic [31:0] trap_cause;
    tval_sel_e   tval_sel;
    logic [31:0] tval_d;

    logic        vec_mode;
    logic        vec_en;
    logic        vec_sel;
    logic [31:0] vec_base;
    logic [31:0] vec_offs;
    logic [31:0] trap_target;

    trap_prio_encoder u_prio (
        .mtime_exc     (mtime_exc_i),
        .exc_fetch_mis (exc_fetch_mis_i),
        .exc_illegal   (exc_illegal_i),
        .exc_ecall     (exc_ecall_i),
        .exc_ebreak    (exc_ebreak_i),
        .exc_load_mis  (exc_load_mis_i),
        .exc_store_mis (exc_store_mis_i),
        .trap_vld      (trap_vld),
        .trap_cause    (trap_cause),
        .tval_sel      (tval_sel)
    );

    // Trap value source mux
    always_comb begin
        tval_d = 32'd0;
        case (tval_sel)
            TVAL_BADADDR: tval_d = badaddr_i;
            TVAL_INSTR:   tval_d = instr_i;
            TVAL_PC:      tval_d = pc_i;
            default:      tval_d = 32'd0;
        endcase
    end

`ifdef TRAP_VECTORED_EN
    assign vec_en = 1'b1;
`else
    // mtvec mode bits are accepted but vectoring is not built in: always direct
    assign vec_en = 1'b0;
`endif

    assign vec_mode    = (mtvec_i[1:0] == 2'b01);
    assign vec_sel     = vec_en & vec_mode & cause_q[31];
    assign vec_base    = {mtvec_i[31:2], 2'b00};
    assign vec_offs    = 32'(VECTOR_STRIDE) * {1'b0, cause_q[30:0]};
    assign trap_target = vec_sel ? (vec_base + vec_offs) : vec_base;

    // Captured trap info is presented continuously and only changes on capture
    assign excCause_o = cause_q;
    assign trapInfo_o = tval_q;
    assign trap_pc_o  = pc_q;

    // State register and trap capture; reset wipes captured values
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cause_q <= 32'd0;
            tval_q  <= 32'd0;
            pc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                cause_q <= trap_cause;
                tval_q  <= tval_d;
                pc_q    <= pc_i;
            end
        end
    end

    // Next state and control outputs; reset masks outputs so an aborted
    // redirect cycle never produces a visible pulse
    always_comb begin
        state_d          = state_q;
        capture          = 1'b0;
        stall_o          = 1'b0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'd0;
        jumpingToMtvec_o = 1'b0;
        mret_o           = 1'b0;
        if (rst) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (instr_valid_i) begin
                        if (trap_vld) begin
                            stall_o = 1'b1;
                            capture = 1'b1;
                            state_d = TRAP_ENTER;
                        end else if (mret_i) begin
                            stall_o = 1'b1;
                            state_d = MRET_EXIT;
                        end
                    end
                end
                TRAP_ENTER: begin
                    jumpingToMtvec_o = 1'b1;
                    flush_o          = 1'b1;
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = trap_target;
                    state_d          = RUN;
                end
                MRET_EXIT: begin
                    mret_o           = 1'b1;
                    flush_o          = 1'b1;
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = mepc_i;
                    state_d          = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed self-checking bench for trap_controller.
// Inputs change just after the falling edge, outputs are checked 1 time unit later.
// Expected values are hand-computed constants in each scenario task.
module tb_trap_controller;
    import trap_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid_i;
    logic [31:0] pc_i, instr_i, badaddr_i;
    logic        exc_fetch_mis_i, exc_illegal_i, exc_ecall_i, exc_ebreak_i;
    logic        exc_load_mis_i, exc_store_mis_i, mret_i, mtime_exc_i;
    logic [31:0] mtvec_i, mepc_i;
    logic        jumpingToMtvec_o, stall_o, flush_o, redirect_valid_o, mret_o;
    logic [31:0] excCause_o, trapInfo_o, trap_pc_o, redirect_pc_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    trap_controller #(.VECTOR_STRIDE(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .instr_valid_i    (instr_valid_i),
        .pc_i             (pc_i),
        .instr_i          (instr_i),
        .badaddr_i        (badaddr_i),
        .exc_fetch_mis_i  (exc_fetch_mis_i),
        .exc_illegal_i    (exc_illegal_i),
        .exc_ecall_i      (exc_ecall_i),
        .exc_ebreak_i     (exc_ebreak_i),
        .exc_load_mis_i   (exc_load_mis_i),
        .exc_store_mis_i  (exc_store_mis_i),
        .mret_i           (mret_i),
        .mtime_exc_i      (mtime_exc_i),
        .mtvec_i          (mtvec_i),
        .mepc_i           (mepc_i),
        .jumpingToMtvec_o (jumpingToMtvec_o),
        .excCause_o       (excCause_o),
        .trapInfo_o       (trapInfo_o),
        .trap_pc_o        (trap_pc_o),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .mret_o           (mret_o)
    );

    task automatic idle_inputs();
        instr_valid_i   = 1'b0;
        exc_fetch_mis_i = 1'b0;
        exc_illegal_i   = 1'b0;
        exc_ecall_i     = 1'b0;
        exc_ebreak_i    = 1'b0;
        exc_load_mis_i  = 1'b0;
        exc_store_mis_i = 1'b0;
        mret_i          = 1'b0;
        mtime_exc_i     = 1'b0;
    endtask

    // Advance to the next falling edge, leaving inputs idle
    task automatic next_idle();
        @(negedge clk);
        idle_inputs();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        pc_i = 32'd0; instr_i = 32'd0; badaddr_i = 32'd0;
        mtvec_i = 32'h200; mepc_i = 32'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if ({stall_o, flush_o, redirect_valid_o, jumpingToMtvec_o, mret_o} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000",
                     {stall_o, flush_o, redirect_valid_o, jumpingToMtvec_o, mret_o});
        else n_pass++;
        n_total++;
        if ({excCause_o, trapInfo_o, trap_pc_o, redirect_pc_o} !== 128'd0)
            $display("FAIL reset_data got %h %h %h %h want 0", excCause_o, trapInfo_o,
                     trap_pc_o, redirect_pc_o);
        else n_pass++;
    endtask

    task automatic test_ecall();
        @(negedge clk);
        idle_inputs();
        instr_valid_i = 1'b1; exc_ecall_i = 1'b1; pc_i = 32'h100; mtvec_i = 32'h200;
        #1;
        n_total++;
        if (stall_o !== 1'b1 || jumpingToMtvec_o !== 1'b0)
            $display("FAIL ecall_stall got stall=%b jump=%b want 1 0", stall_o, jumpingToMtvec_o);
        else n_pass++;
        next_idle();
        n_total++;
        if ({jumpingToMtvec_o, flush_o, redirect_valid_o, mret_o, stall_o} !== 5'b11100)
            $display("FAIL ecall_enter_ctrl got %b want 11100",
                     {jumpingToMtvec_o, flush_o, redirect_valid_o, mret_o, stall_o});
        else n_pass++;
        n_total++;
        if (excCause_o !== 32'd11 || trap_pc_o !== 32'h100 || trapInfo_o !== 32'd0)
            $display("FAIL ecall_capture got cause=%h pc=%h tval=%h want b 100 0",
                     excCause_o, trap_pc_o, trapInfo_o);
        else n_pass++;
        n_total++;
        if (redirect_pc_o !== 32'h200)
            $display("FAIL ecall_redirect got %h want 00000200", redirect_pc_o);
        else n_pass++;
        next_idle();
        n_total++;
        if (jumpingToMtvec_o !== 1'b0 || redirect_valid_o !== 1'b0 || excCause_o !== 32'd11)
            $display("FAIL ecall_after got jump=%b rv=%b cause=%h want 0 0 b",
                     jumpingToMtvec_o, redirect_valid_o, excCause_o);
        else n_pass++;
    endtask

    task automatic test_timer_priority();
        @(negedge clk);
        idle_inputs();
        instr_valid_i = 1'b1; mtime_exc_i = 1'b1; exc_illegal_i = 1'b1;
        instr_i = 32'hDEAD_BEEF; pc_i = 32'h180; mtvec_i = 32'h200;
        #1;
        n_total++;
        if (stall_o !== 1'b1) $display("FAIL timer_stall got %b want 1", stall_o);
        else n_pass++;
        next_idle();
        n_total++;
        if (excCause_o !== 32'h8000_0007 || trapInfo_o !== 32'd0 || jumpingToMtvec_o !== 1'b1)
            $display("FAIL timer_prio got cause=%h tval=%h jump=%b want 80000007 0 1",
                     excCause_o, trapInfo_o, jumpingToMtvec_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        idle_inputs();
        instr_valid_i = 1'b1; exc_illegal_i = 1'b1; instr_i = 32'h0000_FFFF; pc_i = 32'h104;
        #1;
        n_total++;
        if (stall_o !== 1'b1) $display("FAIL b2b_first_stall got %b want 1", stall_o);
        else n_pass++;
        // TRAP_ENTER: a new exception must be ignored this cycle
        @(negedge clk);
        idle_inputs();
        instr_valid_i = 1'b1; exc_load_mis_i = 1'b1; badaddr_i = 32'h55; pc_i = 32'h108;
        #1;
        n_total++;
        if (stall_o !== 1'b0 || jumpingToMtvec_o !== 1'b1 || excCause_o !== 32'd2 ||
            trapInfo_o !== 32'h0000_FFFF)
            $display("FAIL b2b_enter got stall=%b jump=%b cause=%h tval=%h want 0 1 2 ffff",
                     stall_o, jumpingToMtvec_o, excCause_o, trapInfo_o);
        else n_pass++;
        // Back in RUN: the still-presented exception is now taken
        @(negedge clk);
        #1;
        n_total++;
        if (stall_o !== 1'b1 || jumpingToMtvec_o !== 1'b0)
            $display("FAIL b2b_second_stall got stall=%b jump=%b want 1 0", stall_o, jumpingToMtvec_o);
        else n_pass++;
        next_idle();
        n_total++;
        if (excCause_o !== 32'd4 || trapInfo_o !== 32'h55 || trap_pc_o !== 32'h108)
            $display("FAIL b2b_load_mis got cause=%h tval=%h pc=%h want 4 55 108",
                     excCause_o, trapInfo_o, trap_pc_o);
        else n_pass++;
        // ebreak beats store_mis, tval is the PC
        @(negedge clk);
        idle_inputs();
        instr_valid_i = 1'b1; exc_ebreak_i = 1'b1; exc_store_mis_i = 1'b1;
        pc_i = 32'h10C; badaddr_i = 32'h77;
        next_idle();
        n_total++;
        if (excCause_o !== 32'd3 || trapInfo_o !== 32'h10C)
            $display("FAIL ebreak_prio got cause=%h tval=%h want 3 10c", excCause_o, trapInfo_o);
        else n_pass++;
        @(negedge clk);
        idle_inputs();
        instr_valid_i = 1'b1; exc_store_mis_i = 1'b1; pc_i = 32'h110; badaddr_i = 32'h99;
        next_idle();
        n_total++;
        if (excCause_o !== 32'd6 || trapInfo_o !== 32'h99)
            $display("FAIL store_mis got cause=%h tval=%h want 6 99", excCause_o, trapInfo_o);
        else n_pass++;
    endtask

    task automatic test_mret();
        @(negedge clk);
        idle_inputs();
        instr_valid_i = 1'b1; mret_i = 1'b1; mepc_i = 32'h340;
        #1;
        n_total++;
        if (stall_o !== 1'b1) $display("FAIL mret_stall got %b want 1", stall_o);
        else n_pass++;
        next_idle();
        n_total++;
        if ({mret_o, flush_o, redirect_valid_o, jumpingToMtvec_o} !== 4'b1110 ||
            redirect_pc_o !== 32'h340)
            $display("FAIL mret_exit got ctrl=%b pc=%h want 1110 340",
                     {mret_o, flush_o, redirect_valid_o, jumpingToMtvec_o}, redirect_pc_o);
        else n_pass++;
        next_idle();
        n_total++;
        if (mret_o !== 1'b0) $display("FAIL mret_pulse_width got %b want 0", mret_o);
        else n_pass++;
        // Trap wins over a simultaneous MRET
        @(negedge clk);
        idle_inputs();
        instr_valid_i = 1'b1; mret_i = 1'b1; exc_ecall_i = 1'b1; pc_i = 32'h200;
        next_idle();
        n_total++;
        if (jumpingToMtvec_o !== 1'b1 || mret_o !== 1'b0 || excCause_o !== 32'd11)
            $display("FAIL mret_vs_trap got jump=%b mret=%b cause=%h want 1 0 b",
                     jumpingToMtvec_o, mret_o, excCause_o);
        else n_pass++;
    endtask

    task automatic test_invalid();
        @(negedge clk);
        idle_inputs();
        exc_illegal_i = 1'b1; instr_i = 32'h1234_5678; pc_i = 32'h400;
        #1;
        n_total++;
        if (stall_o !== 1'b0) $display("FAIL invalid_stall got %b want 0", stall_o);
        else n_pass++;
        next_idle();
        n_total++;
        if (jumpingToMtvec_o !== 1'b0 || flush_o !== 1'b0 || excCause_o !== 32'd11 ||
            trap_pc_o !== 32'h200)
            $display("FAIL invalid_no_trap got jump=%b flush=%b cause=%h pc=%h want 0 0 b 200",
                     jumpingToMtvec_o, flush_o, excCause_o, trap_pc_o);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        idle_inputs();
        instr_valid_i = 1'b1; exc_ecall_i = 1'b1; pc_i = 32'h300;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        n_total++;
        if (jumpingToMtvec_o !== 1'b0 || flush_o !== 1'b0 || redirect_valid_o !== 1'b0)
            $display("FAIL abort_no_pulse got jump=%b flush=%b rv=%b want 0 0 0",
                     jumpingToMtvec_o, flush_o, redirect_valid_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if ({stall_o, flush_o, redirect_valid_o, jumpingToMtvec_o, mret_o} !== 5'b0 ||
            {excCause_o, trapInfo_o, trap_pc_o, redirect_pc_o} !== 128'd0)
            $display("FAIL abort_outputs got ctrl=%b cause=%h tval=%h pc=%h rpc=%h want 0",
                     {stall_o, flush_o, redirect_valid_o, jumpingToMtvec_o, mret_o},
                     excCause_o, trapInfo_o, trap_pc_o, redirect_pc_o);
        else n_pass++;
        n_total++;
        if (dut.state_q !== RUN) $display("FAIL abort_state got %0d want RUN", dut.state_q);
        else n_pass++;
        next_idle();
        n_total++;
        if (jumpingToMtvec_o !== 1'b0 || mret_o !== 1'b0)
            $display("FAIL abort_late_pulse got jump=%b mret=%b want 0 0", jumpingToMtvec_o, mret_o);
        else n_pass++;
    endtask

    task automatic test_vectored();
        logic [31:0] exp_timer_pc;
`ifdef TRAP_VECTORED_EN
        exp_timer_pc = 32'h21C;
`else
        exp_timer_pc = 32'h200;
`endif
        @(negedge clk);
        idle_inputs();
        instr_valid_i = 1'b1; mtime_exc_i = 1'b1; mtvec_i = 32'h201; pc_i = 32'h500;
        next_idle();
        n_total++;
        if (redirect_pc_o !== exp_timer_pc || jumpingToMtvec_o !== 1'b1)
            $display("FAIL vec_timer got pc=%h jump=%b want %h 1",
                     redirect_pc_o, jumpingToMtvec_o, exp_timer_pc);
        else n_pass++;
        @(negedge clk);
        idle_inputs();
        instr_valid_i = 1'b1; exc_ecall_i = 1'b1; pc_i = 32'h504;
        next_idle();
        n_total++;
        if (redirect_pc_o !== 32'h200 || excCause_o !== 32'd11)
            $display("FAIL vec_ecall got pc=%h cause=%h want 200 b", redirect_pc_o, excCause_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_timer_priority();
        test_back_to_back();
        test_mret();
        test_invalid();
        test_reset_abort();
        test_vectored();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
